// File: rtl/cluster_seq_pkg.sv
// Shared state encoding, router mode constant and width helper for the cluster sequencer.
package cluster_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FILL_I,
    FILL_W,
    LOAD,
    START,
    COMPUTE,
    DRAIN,
    DONE
  } seq_state_e;

  localparam logic [3:0] MODE_DEFAULT = 4'd0;

  // Bits needed to hold values 0..value-1 (returns 0 for value <= 1).
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/psum_drain_fifo.sv
// Two-entry FIFO holding drained psums (data plus last flag); push and pop may share a cycle.
module psum_drain_fifo #(
  parameter int WIDTH = 17
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [1:0]       count,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [2];
  logic [WIDTH-1:0] mem_d [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ pop;
    count_d  = count_q + {1'b0, push} - {1'b0, pop};
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign pop_data = mem_q[rd_ptr_q];
  assign count    = count_q;
  assign empty    = (count_q == 2'd0);

endmodule

// File: rtl/cluster_seq_ctrl.sv
// Run sequencer around the 1-cluster HMNOC: GLB fill, router load, PE start/compute, psum drain.
// Optional PSUM_RELU_EN clamps negative drained psums to zero at FIFO push.
module cluster_seq_ctrl
  import cluster_seq_pkg::*;
#(
  parameter int         DATA_BITWIDTH = 16,
  parameter int         ADDR_BITWIDTH = 10,
  parameter int         NUM_IACT      = 25,
  parameter int         NUM_WGHT      = 9,
  parameter int         NUM_PSUM      = 9,
  parameter int         IACT_BASE     = 0,
  parameter int         WGHT_BASE     = 0,
  parameter int         PSUM_BASE     = 0,
  parameter logic [3:0] MODE_IACT     = MODE_DEFAULT,
  parameter logic [3:0] MODE_WGHT     = MODE_DEFAULT,
  parameter logic [3:0] MODE_PSUM     = MODE_DEFAULT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cfg_start,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [DATA_BITWIDTH-1:0] s_data,
  output logic                     glb_wen_iact,
  output logic [ADDR_BITWIDTH-1:0] glb_waddr_iact,
  output logic [DATA_BITWIDTH-1:0] glb_wdata_iact,
  output logic                     glb_wen_wght,
  output logic [ADDR_BITWIDTH-1:0] glb_waddr_wght,
  output logic [DATA_BITWIDTH-1:0] glb_wdata_wght,
  output logic                     rtr_en_iact,
  output logic                     rtr_en_wght,
  output logic [3:0]               rtr_mode_iact,
  output logic [3:0]               rtr_mode_wght,
  output logic [3:0]               rtr_mode_psum,
  input  logic                     load_done,
  output logic                     pe_start,
  input  logic                     compute_done,
  output logic                     psum_rreq,
  output logic [ADDR_BITWIDTH-1:0] psum_raddr,
  input  logic [DATA_BITWIDTH-1:0] psum_rdata,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [DATA_BITWIDTH-1:0] m_data,
  output logic                     m_last,
  output logic                     busy,
  output logic                     done
);

  localparam int CNT_MAX_IW = (NUM_IACT > NUM_WGHT) ? NUM_IACT : NUM_WGHT;
  localparam int CNT_MAX    = (CNT_MAX_IW > NUM_PSUM) ? CNT_MAX_IW : NUM_PSUM;
  localparam int CNT_W      = clog2(CNT_MAX + 1);
  localparam longint ADDR_SPAN = longint'(1) << ADDR_BITWIDTH;

  if (longint'(IACT_BASE) + NUM_IACT - 1 >= ADDR_SPAN) begin : g_bad_iact_range
    $error("iact GLB range exceeds address space");
  end
  if (longint'(WGHT_BASE) + NUM_WGHT - 1 >= ADDR_SPAN) begin : g_bad_wght_range
    $error("weight GLB range exceeds address space");
  end
  if (longint'(PSUM_BASE) + NUM_PSUM - 1 >= ADDR_SPAN) begin : g_bad_psum_range
    $error("psum GLB range exceeds address space");
  end

  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] fill_cnt_q, fill_cnt_d;
  logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
  logic             in_flight_q, in_flight_d;
  logic             in_flight_last_q, in_flight_last_d;

  logic [DATA_BITWIDTH:0]   fifo_out;
  logic [DATA_BITWIDTH-1:0] push_word;
  logic [1:0]               fifo_count;
  logic                     fifo_empty;
  logic                     pop;
  logic [2:0]               slots_used;

  assign m_valid = !fifo_empty;
  assign pop     = m_valid && m_ready;
  assign m_data  = m_valid ? fifo_out[DATA_BITWIDTH-1:0] : '0;
  assign m_last  = m_valid && fifo_out[DATA_BITWIDTH];

  // A pop this cycle frees its slot in time for a read issued now, which keeps the drain at one word per cycle.
  assign slots_used = 3'(fifo_count) + 3'(in_flight_q) - 3'(pop);

`ifdef PSUM_RELU_EN
  assign push_word = psum_rdata[DATA_BITWIDTH-1] ? '0 : psum_rdata;
`else
  assign push_word = psum_rdata;
`endif

  psum_drain_fifo #(
    .WIDTH(DATA_BITWIDTH + 1)
  ) u_drain_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (in_flight_q),
    .push_data({in_flight_last_q, push_word}),
    .pop      (pop),
    .pop_data (fifo_out),
    .count    (fifo_count),
    .empty    (fifo_empty)
  );

  assign rtr_mode_iact = MODE_IACT;
  assign rtr_mode_wght = MODE_WGHT;
  assign rtr_mode_psum = MODE_PSUM;
  assign busy          = (state_q != IDLE);

  always_comb begin
    state_d          = state_q;
    fill_cnt_d       = fill_cnt_q;
    rd_cnt_d         = rd_cnt_q;
    in_flight_d      = 1'b0;
    in_flight_last_d = 1'b0;
    s_ready          = 1'b0;
    glb_wen_iact     = 1'b0;
    glb_waddr_iact   = '0;
    glb_wdata_iact   = '0;
    glb_wen_wght     = 1'b0;
    glb_waddr_wght   = '0;
    glb_wdata_wght   = '0;
    rtr_en_iact      = 1'b0;
    rtr_en_wght      = 1'b0;
    pe_start         = 1'b0;
    psum_rreq        = 1'b0;
    psum_raddr       = '0;
    done             = 1'b0;

    case (state_q)
      IDLE: begin
        if (cfg_start) begin
          state_d    = FILL_I;
          fill_cnt_d = '0;
        end
      end
      FILL_I: begin
        s_ready = 1'b1;
        if (s_valid) begin
          glb_wen_iact   = 1'b1;
          glb_waddr_iact = ADDR_BITWIDTH'(IACT_BASE) + ADDR_BITWIDTH'(fill_cnt_q);
          glb_wdata_iact = s_data;
          if (fill_cnt_q == CNT_W'(NUM_IACT - 1)) begin
            fill_cnt_d = '0;
            state_d    = FILL_W;
          end else begin
            fill_cnt_d = fill_cnt_q + 1'b1;
          end
        end
      end
      FILL_W: begin
        s_ready = 1'b1;
        if (s_valid) begin
          glb_wen_wght   = 1'b1;
          glb_waddr_wght = ADDR_BITWIDTH'(WGHT_BASE) + ADDR_BITWIDTH'(fill_cnt_q);
          glb_wdata_wght = s_data;
          if (fill_cnt_q == CNT_W'(NUM_WGHT - 1)) begin
            fill_cnt_d = '0;
            state_d    = LOAD;
          end else begin
            fill_cnt_d = fill_cnt_q + 1'b1;
          end
        end
      end
      LOAD: begin
        rtr_en_iact = 1'b1;
        rtr_en_wght = 1'b1;
        if (load_done) begin
          state_d = START;
        end
      end
      START: begin
        pe_start = 1'b1;
        state_d  = COMPUTE;
      end
      COMPUTE: begin
        if (compute_done) begin
          state_d  = DRAIN;
          rd_cnt_d = '0;
        end
      end
      DRAIN: begin
        if ((slots_used < 3'd2) && (rd_cnt_q < CNT_W'(NUM_PSUM))) begin
          psum_rreq        = 1'b1;
          psum_raddr       = ADDR_BITWIDTH'(PSUM_BASE) + ADDR_BITWIDTH'(rd_cnt_q);
          rd_cnt_d         = rd_cnt_q + 1'b1;
          in_flight_d      = 1'b1;
          in_flight_last_d = (rd_cnt_q == CNT_W'(NUM_PSUM - 1));
        end
        if (pop && fifo_out[DATA_BITWIDTH]) begin
          state_d = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q          <= IDLE;
      fill_cnt_q       <= '0;
      rd_cnt_q         <= '0;
      in_flight_q      <= 1'b0;
      in_flight_last_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      fill_cnt_q       <= fill_cnt_d;
      rd_cnt_q         <= rd_cnt_d;
      in_flight_q      <= in_flight_d;
      in_flight_last_q <= in_flight_last_d;
    end
  end

endmodule

// File: tb/tb_cluster_seq_ctrl.sv
// Randomized self-checking bench for cluster_seq_ctrl against a queue-based run model.
module tb_cluster_seq_ctrl;

  localparam int NI = 25;
  localparam int NW = 9;
  localparam int NP = 9;
  localparam int IB = 0;
  localparam int WB = 0;
  localparam int PB = 0;

  logic        clk = 1'b0;
  logic        reset, cfg_start, s_valid, s_ready;
  logic [15:0] s_data;
  logic        glb_wen_iact, glb_wen_wght;
  logic [9:0]  glb_waddr_iact, glb_waddr_wght;
  logic [15:0] glb_wdata_iact, glb_wdata_wght;
  logic        rtr_en_iact, rtr_en_wght;
  logic [3:0]  rtr_mode_iact, rtr_mode_wght, rtr_mode_psum;
  logic        load_done, pe_start, compute_done, psum_rreq;
  logic [9:0]  psum_raddr;
  logic [15:0] psum_rdata;
  logic        m_valid, m_ready, m_last, busy, done;
  logic [15:0] m_data;

  always #5 clk = ~clk;

  cluster_seq_ctrl dut (
    .clk(clk), .reset(reset), .cfg_start(cfg_start),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .glb_wen_iact(glb_wen_iact), .glb_waddr_iact(glb_waddr_iact), .glb_wdata_iact(glb_wdata_iact),
    .glb_wen_wght(glb_wen_wght), .glb_waddr_wght(glb_waddr_wght), .glb_wdata_wght(glb_wdata_wght),
    .rtr_en_iact(rtr_en_iact), .rtr_en_wght(rtr_en_wght),
    .rtr_mode_iact(rtr_mode_iact), .rtr_mode_wght(rtr_mode_wght), .rtr_mode_psum(rtr_mode_psum),
    .load_done(load_done), .pe_start(pe_start), .compute_done(compute_done),
    .psum_rreq(psum_rreq), .psum_raddr(psum_raddr), .psum_rdata(psum_rdata),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .busy(busy), .done(done)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  // GLB psum contents as seen by the bench: either an affine ramp or a constant negative value.
  int psum_mul = 3;
  int psum_add = 0;
  bit psum_neg = 1'b0;

  function automatic logic [15:0] psum_of(input logic [9:0] a);
    if (psum_neg) return 16'hFFF6;
    return 16'(int'(a) * psum_mul + psum_add);
  endfunction

  function automatic logic [15:0] expected_word(input int k);
    logic [15:0] v;
    v = psum_of(10'(PB + k));
`ifdef PSUM_RELU_EN
    if ($signed(v) < 0) v = 16'h0000;
`endif
    return v;
  endfunction

  function automatic logic outs_any();
    return |{s_ready, glb_wen_iact, glb_waddr_iact, glb_wdata_iact, glb_wen_wght, glb_waddr_wght,
             glb_wdata_wght, rtr_en_iact, rtr_en_wght, pe_start, psum_rreq, psum_raddr,
             m_valid, m_data, m_last, busy, done};
  endfunction

  // Read responder: data for a request appears during the following cycle only.
  logic       req_seen = 1'b0;
  logic [9:0] req_addr = '0;
  always @(negedge clk) begin
    req_seen = psum_rreq;
    req_addr = psum_raddr;
  end
  always @(posedge clk) begin
    #1;
    psum_rdata = req_seen ? psum_of(req_addr) : 16'($urandom);
  end

  // Event log sampled mid-cycle.
  logic [31:0] ia_q[$], id_q[$], wa_q[$], wd_q[$], od_q[$], ol_q[$], oc_q[$];
  int cyc = 0, rtr_cnt, rtr_last, rtr_diff, pe_cnt, pe_cyc, done_cnt, guard_err;
  bit in_compute = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (glb_wen_iact) begin ia_q.push_back(32'(glb_waddr_iact)); id_q.push_back(32'(glb_wdata_iact)); end
    if (glb_wen_wght) begin wa_q.push_back(32'(glb_waddr_wght)); wd_q.push_back(32'(glb_wdata_wght)); end
    if (rtr_en_iact) begin rtr_cnt++; rtr_last = cyc; end
    if (rtr_en_iact != rtr_en_wght) rtr_diff++;
    if (pe_start) begin pe_cnt++; pe_cyc = cyc; end
    if (m_valid && m_ready) begin
      od_q.push_back(32'(m_data)); ol_q.push_back(32'(m_last)); oc_q.push_back(32'(cyc));
    end
    if (done) done_cnt++;
    if (in_compute && (s_ready || glb_wen_iact || glb_wen_wght)) guard_err++;
  end

  task automatic clear_logs();
    ia_q.delete(); id_q.delete(); wa_q.delete(); wd_q.delete();
    od_q.delete(); ol_q.delete(); oc_q.delete();
    rtr_cnt = 0; rtr_last = 0; rtr_diff = 0; pe_cnt = 0; pe_cyc = 0; done_cnt = 0; guard_err = 0;
  endtask

  // rmode: 0 = m_ready high, 1 = toggle 1010.., 2 = random.  abort_after>0 resets after that many words.
  task automatic run_once(input int run_id, input bit nominal, input int gap, input int rmode,
                          input int ld, input int cd, input bit inject, input bit neg, input int abort_after);
    logic [15:0] vals[NI+NW];
    int idx, guard;
    bit tog;
    clear_logs();
    psum_neg = neg;
    psum_mul = nominal ? 3 : int'($urandom_range(1, 4000));
    psum_add = nominal ? 0 : int'($urandom);
    for (int i = 0; i < NI + NW; i++)
      vals[i] = nominal ? ((i < NI) ? 16'(i) : 16'(100 + i - NI)) : 16'($urandom);

    @(posedge clk); #1; cfg_start = 1'b1;
    @(posedge clk); #1; cfg_start = 1'b0;

    idx = 0; guard = 0;
    while (idx < NI + NW && guard < 1000) begin
      s_valid = ($urandom_range(99) >= gap);
      s_data  = vals[idx];
      cfg_start = (inject && idx >= NI) ? 1'($urandom_range(1)) : 1'b0;
      @(negedge clk);
      if (s_valid && s_ready) idx++;
      @(posedge clk); #1; guard++;
    end
    s_valid = 1'b0; s_data = '0; cfg_start = 1'b0;
    check("stream_accepted", idx, NI + NW);

    repeat (ld - 1) begin @(posedge clk); #1; end
    load_done = 1'b1;
    @(posedge clk); #1; load_done = 1'b0;
    in_compute = 1'b1;
    if (inject) begin s_valid = 1'b1; s_data = 16'($urandom); end
    if (rmode == 0) m_ready = 1'b1;
    compute_done = (cd == 0);
    if (cd > 0) begin
      repeat (cd) begin @(posedge clk); #1; end
      compute_done = 1'b1;
    end
    repeat (2) begin @(posedge clk); #1; end
    compute_done = 1'b0; in_compute = 1'b0; s_valid = 1'b0;

    tog = 1'b1; guard = 0;
    while (done_cnt == 0 && guard < 500) begin
      m_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? tog : 1'($urandom_range(1));
      tog = ~tog;
      @(negedge clk); #1;
      if (abort_after > 0 && od_q.size() >= abort_after) break;
      @(posedge clk); #1; guard++;
    end

    check("iact_count", ia_q.size(), NI);
    for (int i = 0; i < ia_q.size() && i < NI; i++) begin
      check("iact_addr", ia_q[i], IB + i);
      check("iact_data", id_q[i], 32'(vals[i]));
    end
    check("wght_count", wa_q.size(), NW);
    for (int i = 0; i < wa_q.size() && i < NW; i++) begin
      check("wght_addr", wa_q[i], WB + i);
      check("wght_data", wd_q[i], 32'(vals[NI + i]));
    end
    check("rtr_cycles", rtr_cnt, ld);
    check("rtr_pair", rtr_diff, 0);
    check("pe_pulse", pe_cnt, 1);
    check("pe_after_load", pe_cyc, rtr_last + 1);
    check("guard_no_accept", guard_err, 0);

    if (abort_after > 0) begin
      @(posedge clk); #1; m_ready = 1'b0; reset = 1'b0;
      @(posedge clk); #1; reset = 1'b1;
      @(negedge clk);
      check("abort_outs_zero", 32'(outs_any()), 0);
      check("abort_modes", {rtr_mode_iact, rtr_mode_wght, rtr_mode_psum}, 0);
      m_ready = 1'b1; s_valid = 1'b1;
      repeat (10) @(posedge clk);
      #1; s_valid = 1'b0; m_ready = 1'b0;
      check("abort_words", od_q.size(), abort_after);
      check("abort_writes", ia_q.size() + wa_q.size(), NI + NW);
      check("abort_done", done_cnt, 0);
      for (int k = 0; k < od_q.size() && k < NP; k++)
        check("abort_m_data", od_q[k], 32'(expected_word(k)));
      $display("run %0d: aborted after %0d words", run_id, od_q.size());
      return;
    end

    repeat (3) @(negedge clk);
    #1; m_ready = 1'b0;
    check("m_count", od_q.size(), NP);
    for (int k = 0; k < od_q.size() && k < NP; k++) begin
      check("m_data", od_q[k], 32'(expected_word(k)));
      check("m_last", ol_q[k], 32'(k == NP - 1));
    end
    if (rmode == 0 && od_q.size() == NP) check("m_burst_span", oc_q[NP-1] - oc_q[0], NP - 1);
    check("done_pulse", done_cnt, 1);
    check("busy_after", 32'(busy), 0);
    $display("run %0d: iact=%0d wght=%0d words=%0d rtr=%0d", run_id, ia_q.size(), wa_q.size(),
             od_q.size(), rtr_cnt);
  endtask

  initial begin
    reset = 1'b0; cfg_start = 1'b0; s_valid = 1'b0; s_data = '0;
    load_done = 1'b0; compute_done = 1'b0; m_ready = 1'b0; psum_rdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outs_zero", 32'(outs_any()), 0);
    check("reset_modes", {rtr_mode_iact, rtr_mode_wght, rtr_mode_psum}, 0);
    @(posedge clk); #1; reset = 1'b1;

    run_once(0, 1'b1, 0, 1, 7, 3, 1'b1, 1'b0, 0);
    run_once(1, 1'b0, 30, 0, int'($urandom_range(1, 10)), 0, 1'b0, 1'b0, 0);
    run_once(2, 1'b0, 20, 2, int'($urandom_range(1, 10)), int'($urandom_range(0, 5)), 1'b1, 1'b0, 0);
    run_once(3, 1'b0, 0, 0, 3, 2, 1'b0, 1'b1, 0);
    run_once(4, 1'b1, 0, 1, 4, 1, 1'b0, 1'b0, 4);
    run_once(5, 1'b1, 10, 1, 7, 3, 1'b0, 1'b0, 0);
    for (int r = 6; r < 10; r++)
      run_once(r, 1'b0, int'($urandom_range(0, 50)), int'($urandom_range(0, 2)),
               int'($urandom_range(1, 12)), int'($urandom_range(0, 6)), 1'($urandom_range(1)), 1'b0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
